// File: rtl/scope_capture_pkg.sv
// Shared types and helpers for the scope_capture acquisition/readout block.
// Holds the FSM state encoding, the trigger-mode codes and the buffer sizing functions.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;

    function automatic int depth_of(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

    // Samples captured from the trigger sample onwards.
    function automatic int post_len(input int addr_w, input int pretrig);
        return depth_of(addr_w) - pretrig;
    endfunction

endpackage

// File: rtl/scope_capture_sample_ram.sv
// Simple dual-port sample buffer: one write port and a registered read port on one clock.
// Written so that it maps onto a single block RAM.
module sample_ram
    import scope_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:depth_of(ADDR_W)-1];
    logic [DATA_W-1:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port, one cycle of latency
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/scope_capture.sv
// Oscilloscope acquisition: circular pre/post-trigger capture of ADC samples, then an
// oldest-first readout over a valid/ready interface with a skid register for full throughput.
module scope_capture
    import scope_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 9,
    parameter int PRETRIG = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              force_trig,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              triggered,
    output logic              done
);

    localparam int                DEPTH       = depth_of(ADDR_W);
    localparam int                CW          = ADDR_W + 1;
    localparam int                POST_N      = post_len(ADDR_W, PRETRIG);
    localparam logic [CW-1:0]     DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0]     LAST_IDX_C  = CW'(DEPTH - 1);
    localparam logic [CW-1:0]     PRE_LAST_C  = CW'((PRETRIG > 0) ? PRETRIG - 1 : 0);
    localparam logic [CW-1:0]     POST_LAST_C = CW'((POST_N > 0) ? POST_N - 1 : 0);
    localparam logic [CW-1:0]     ONE_C       = CW'(1);
    localparam logic [ADDR_W-1:0] A_ONE_C     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_A_C     = ADDR_W'(PRETRIG);

    if (PRETRIG < 0 || PRETRIG > DEPTH - 1) begin : g_pretrig_range
        $error("scope_capture: PRETRIG must lie in 0..DEPTH-1");
    end

    state_e              state_r, state_s;
    logic [ADDR_W-1:0]   wptr_r, start_addr_r, raddr_s;
    logic [CW-1:0]       pre_cnt_r, post_cnt_r, rd_cnt_r, sent_cnt_r;
    logic [1:0]          mode_r;
    logic [DATA_W-1:0]   level_r, prev_r;
    logic                prev_ok_r;
    logic [DATA_W-1:0]   out_data_r, skid_r, rdata_s;
    logic                out_valid_r, skid_v_r, rd_pend_r;
    logic                busy_r, trig_r, done_r;
    logic                we_s, re_s, pop_s, fire_s, arm_ok_s, hit_s, rise_s, fall_s;
    logic [1:0]          occ_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    if (arm) state_s = (PRETRIG == 0) ? ST_ARMED : ST_PREFILL;
                        else     state_s = ST_IDLE;
            ST_PREFILL: if (smp_valid && pre_cnt_r == PRE_LAST_C) state_s = ST_ARMED;
                        else                                      state_s = ST_PREFILL;
            ST_ARMED:   if (fire_s) state_s = (POST_N == 1) ? ST_SEND : ST_POST;
                        else        state_s = ST_ARMED;
            ST_POST:    if (smp_valid && post_cnt_r == POST_LAST_C) state_s = ST_SEND;
                        else                                        state_s = ST_POST;
            ST_SEND:    if (done_r) state_s = ST_IDLE;
                        else        state_s = ST_SEND;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Per-state strobes: RAM write, trigger fire, read issue
    always_comb begin
        we_s     = 1'b0;
        re_s     = 1'b0;
        fire_s   = 1'b0;
        arm_ok_s = 1'b0;
        rise_s   = prev_ok_r && (prev_r < level_r) && (smp_data >= level_r);
        fall_s   = prev_ok_r && (prev_r > level_r) && (smp_data <= level_r);
        pop_s    = out_valid_r && out_ready;
        occ_s    = {1'b0, out_valid_r} + {1'b0, skid_v_r} + {1'b0, rd_pend_r};
        case (mode_r)
            TRIG_IMM:  hit_s = 1'b1;
            TRIG_RISE: hit_s = rise_s;
            TRIG_FALL: hit_s = fall_s;
            default:   hit_s = 1'b1;
        endcase
        case (state_r)
            ST_IDLE:    arm_ok_s = arm;
            ST_PREFILL: we_s = smp_valid;
            ST_ARMED: begin
                we_s   = smp_valid;
                fire_s = smp_valid && (force_trig || hit_s);
            end
            ST_POST:    we_s = smp_valid;
            // Keep at most two samples in flight or buffered so the skid never overflows.
            ST_SEND:    re_s = (rd_cnt_r < DEPTH_C) && ((occ_s - {1'b0, pop_s}) <= 2'd1);
            default:    we_s = 1'b0;
        endcase
    end

    // Capture bookkeeping: write pointer, trigger settings, pre/post counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r       <= '0;
            start_addr_r <= '0;
            pre_cnt_r    <= '0;
            post_cnt_r   <= '0;
            mode_r       <= TRIG_IMM;
            level_r      <= '0;
            prev_r       <= '0;
            prev_ok_r    <= 1'b0;
        end else begin
            if (arm_ok_s) begin
                mode_r    <= trig_mode;
                level_r   <= trig_level;
                pre_cnt_r <= '0;
                prev_ok_r <= 1'b0;
            end
            if (we_s) begin
                wptr_r <= wptr_r + A_ONE_C;
            end
            if (state_r == ST_PREFILL && smp_valid) begin
                pre_cnt_r <= pre_cnt_r + ONE_C;
            end
            if ((state_r == ST_PREFILL || state_r == ST_ARMED) && smp_valid) begin
                prev_r    <= smp_data;
                prev_ok_r <= 1'b1;
            end
            if (fire_s) begin
                start_addr_r <= wptr_r - PRE_A_C;
                post_cnt_r   <= ONE_C;
            end else if (state_r == ST_POST && smp_valid) begin
                post_cnt_r <= post_cnt_r + ONE_C;
            end
        end
    end

    assign raddr_s = start_addr_r + rd_cnt_r[ADDR_W-1:0];

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wptr_r),
        .wdata (smp_data),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Readout pipeline: RAM data lands in the output register, or in the skid when stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_r    <= '0;
            sent_cnt_r  <= '0;
            rd_pend_r   <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            skid_r      <= '0;
            skid_v_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rd_pend_r <= re_s;
            done_r    <= pop_s && (sent_cnt_r == LAST_IDX_C);
            if (arm_ok_s) begin
                rd_cnt_r   <= '0;
                sent_cnt_r <= '0;
            end else begin
                if (re_s)  rd_cnt_r   <= rd_cnt_r + ONE_C;
                if (pop_s) sent_cnt_r <= sent_cnt_r + ONE_C;
            end
            if (!out_valid_r || out_ready) begin
                if (skid_v_r) begin
                    out_data_r  <= skid_r;
                    out_valid_r <= 1'b1;
                    skid_v_r    <= rd_pend_r;
                    if (rd_pend_r) skid_r <= rdata_s;
                end else if (rd_pend_r) begin
                    out_data_r  <= rdata_s;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else if (rd_pend_r) begin
                skid_r   <= rdata_s;
                skid_v_r <= 1'b1;
            end
        end
    end

    // Status flags follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            trig_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            trig_r <= (state_s == ST_POST) || (state_s == ST_SEND);
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign triggered = trig_r;
    assign done      = done_r;

endmodule

// File: tb/tb_scope_capture.sv
// Randomised bench for scope_capture (DEPTH 16, PRETRIG 4): each acquisition is predicted by
// scanning the fed sample list for the trigger, then the stream is compared to the window around it.
module tb_scope_capture;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int PRETRIG = 4;
    localparam int DEPTH   = 16;
    localparam int POST_N  = DEPTH - PRETRIG;
    localparam int NSMP    = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              smp_valid = 1'b0;
    logic [DATA_W-1:0] smp_data = 8'h00;
    logic              arm = 1'b0;
    logic [1:0]        trig_mode = 2'b00;
    logic [DATA_W-1:0] trig_level = 8'h00;
    logic              force_trig = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy, triggered, done;

    always #5 clk = ~clk;

    scope_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG)) dut (
        .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data), .arm(arm),
        .trig_mode(trig_mode), .trig_level(trig_level), .force_trig(force_trig),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .triggered(triggered), .done(done)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] smp_a [0:NSMP-1];
    bit         frc_a [0:NSMP-1];

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Index (counted over accepted samples since arm) of the sample that triggers.
    function automatic int find_trig(input logic [1:0] mode, input logic [7:0] level);
        for (int k = PRETRIG; k < NSMP; k++) begin
            bit hit;
            hit = frc_a[k];
            if (mode == 2'b01)
                hit = hit || (k > 0 && smp_a[k-1] < level && smp_a[k] >= level);
            else if (mode == 2'b10)
                hit = hit || (k > 0 && smp_a[k-1] > level && smp_a[k] <= level);
            else
                hit = 1'b1;
            if (hit) return k;
        end
        return -1;
    endfunction

    task automatic fill_random(input int force_at);
        for (int i = 0; i < NSMP; i++) begin
            smp_a[i] = 8'($urandom);
            frc_a[i] = (i == force_at);
        end
    endtask

    task automatic rst_check(input string tag);
        rst = 1'b1; arm = 1'b0; smp_valid = 1'b0; force_trig = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_val({tag, "_rst_valid"}, out_valid, 0);
        check_val({tag, "_rst_busy"}, busy, 0);
        check_val({tag, "_rst_trig"}, triggered, 0);
        check_val({tag, "_rst_done"}, done, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // abort_at: 0 run to completion, 1 reset during POST, 2 reset during SEND
    task automatic do_capture(input logic [1:0] mode, input logic [7:0] level,
                              input int valid_pct, input int ready_pct, input int abort_at);
        int t, need, written, got, cyc, first_v, first_hs, last_hs, early_done;
        bit drv, stalled;
        logic [7:0] held;
        t    = find_trig(mode, level);
        need = t + POST_N;

        @(negedge clk);
        arm = 1'b1; trig_mode = mode; trig_level = level;
        smp_valid = 1'b0; force_trig = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        trig_mode = 2'($urandom); trig_level = 8'($urandom);
        check_val("busy_after_arm", busy, 1);
        check_val("trig_after_arm", triggered, 0);

        written = 0;
        while (written < need) begin
            drv = (int'($urandom_range(99)) < valid_pct);
            if (drv) begin
                smp_valid = 1'b1; smp_data = smp_a[written]; force_trig = frc_a[written];
            end else begin
                smp_valid = 1'b0; smp_data = 8'($urandom); force_trig = 1'($urandom);
            end
            @(negedge clk);
            if (drv) begin
                written++;
                if (written == t)     check_val("trig_before", triggered, 0);
                if (written == t + 1) check_val("trig_on_sample", triggered, 1);
            end
            if (abort_at == 1 && written == t + 2) begin
                rst_check("post");
                return;
            end
        end

        got = 0; cyc = 0; first_v = -1; first_hs = -1; last_hs = -1;
        early_done = 0; stalled = 1'b0; held = 8'h00;
        while (got < DEPTH && cyc < 400) begin
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) early_done++;
            if (stalled) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, held);
            end
            out_ready  = (int'($urandom_range(99)) < ready_pct);
            smp_valid  = 1'($urandom);
            smp_data   = 8'($urandom);
            force_trig = 1'($urandom);
            arm        = (cyc == 3);
            if (out_valid && out_ready) begin
                check_val("stream_data", out_data, smp_a[t - PRETRIG + got]);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (abort_at == 2 && got == 5) begin
                rst_check("send");
                return;
            end
            @(negedge clk);
            cyc++;
        end
        arm = 1'b0; out_ready = 1'b0; smp_valid = 1'b0; force_trig = 1'b0;
        check_val("stream_count", got, DEPTH);
        check_val("no_early_done", early_done, 0);
        check_val("first_valid_latency", int'(first_v >= 0 && first_v <= 2), 1);
        if (ready_pct >= 100) check_val("b2b_span", last_hs - first_hs, DEPTH - 1);
        check_val("done_pulse", done, 1);
        check_val("valid_drop", out_valid, 0);
        @(negedge clk);
        check_val("done_single", done, 0);
        check_val("busy_end", busy, 0);
        check_val("trig_end", triggered, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_valid", out_valid, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_trig", triggered, 0);
        check_val("reset_done", done, 0);
        check_val("reset_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Immediate mode, ramp on every cycle
        for (int i = 0; i < NSMP; i++) begin smp_a[i] = 8'(i); frc_a[i] = 1'b0; end
        do_capture(2'b00, 8'h00, 100, 100, 0);

        // Rising edge through 0x80
        fill_random(-1);
        for (int i = 0; i < 40; i++) smp_a[i] = 8'h10;
        smp_a[40] = 8'h90;
        do_capture(2'b01, 8'h80, 100, 100, 0);

        // Falling edge through 0x40
        fill_random(-1);
        smp_a[0] = 8'h20;
        for (int i = 1; i < 5; i++) smp_a[i] = 8'h50;
        smp_a[5] = 8'h30;
        do_capture(2'b10, 8'h40, 80, 100, 0);

        // Heavy backpressure
        fill_random(30);
        do_capture(2'b01, 8'($urandom), 70, 30, 0);

        // Forced trigger in rising mode with input below level, after a wrapped prefill
        for (int i = 0; i < NSMP; i++) begin smp_a[i] = 8'(i & 8'h3f); frc_a[i] = (i == 37); end
        do_capture(2'b01, 8'h80, 60, 70, 0);

        // Random modes (including the reserved code), levels and handshake rates
        for (int r = 0; r < 4; r++) begin
            fill_random(int'($urandom_range(60, 20)));
            do_capture(2'($urandom), 8'($urandom), int'($urandom_range(100, 50)),
                       int'($urandom_range(100, 20)), 0);
        end

        // Aborts mid-POST and mid-SEND, then a clean acquisition
        fill_random(30);
        do_capture(2'b01, 8'h80, 90, 100, 1);
        fill_random(25);
        do_capture(2'b11, 8'h00, 90, 60, 2);
        for (int i = 0; i < NSMP; i++) begin smp_a[i] = 8'(8'h40 + i); frc_a[i] = 1'b0; end
        do_capture(2'b00, 8'h00, 100, 100, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
